// File: rtl/clk_div_sched.sv
// clk_div_sched: runtime-programmable integer clock divider, 50% duty for odd and even ratios,
// runt-free start/stop and period-aligned ratio updates. Optional macro CLK_DIV_SCHED_STAT_EN adds PERIOD_CNT.
module clk_div_sched #(
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned DEF_DIV = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             CFG_VALID,
    input  logic [DIV_W-1:0] CFG_DIV,
    output logic             CFG_READY,
    output logic             CFG_ERR,
    output logic             CLK_OUT,
    output logic             TICK,
    output logic             BUSY,
    output logic [DIV_W-1:0] ACTIVE_DIV
`ifdef CLK_DIV_SCHED_STAT_EN
    ,
    output logic [31:0]      PERIOD_CNT
`endif
);
    localparam int unsigned XW = DIV_W + 1;

    typedef enum logic [1:0] {STOP = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t           state_q, state_n;
    logic [DIV_W-1:0] cnt_q, cnt_n;
    logic [DIV_W-1:0] div_n;
    logic [DIV_W-1:0] pdiv_q, pdiv_n;
    logic             pend_q, pend_n;
    logic             clk_a_q, clk_a_n;
    logic             odd_q;
    logic             clk_b_q;
    logic             tick_n, busy_n, err_n;
    logic             running, wrap, xfer, legal;
    logic [XW-1:0]    cnt_x, div_x, half_x;

    // Period decode in DIV_W+1 bits so the maximum ratio cannot overflow.
    always_comb begin
        running = (state_q != STOP);
        cnt_x   = {1'b0, cnt_q};
        div_x   = {1'b0, ACTIVE_DIV};
        half_x  = (div_x + XW'(1)) >> 1;
        wrap    = running && ((cnt_x + XW'(1)) == div_x);
        xfer    = CFG_VALID && CFG_READY;
        legal   = (CFG_DIV >= DIV_W'(2));
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        div_n   = ACTIVE_DIV;
        pdiv_n  = pdiv_q;
        pend_n  = pend_q;
        err_n   = xfer && !legal;
        clk_a_n = running && (cnt_x < half_x);

        case (state_q)
            STOP: begin
                cnt_n = '0;
                if (EN) state_n = RUN;
            end
            RUN: begin
                cnt_n = wrap ? '0 : cnt_q + DIV_W'(1);
                if (!EN) state_n = DRAIN;
            end
            DRAIN: begin
                cnt_n = wrap ? '0 : cnt_q + DIV_W'(1);
                if (EN)        state_n = RUN;
                else if (wrap) state_n = STOP;
            end
            default: state_n = STOP;
        endcase

        // Idle: ratio lands immediately; running: staged until the next wrap.
        if (!running) begin
            if (pend_q) begin
                div_n  = pdiv_q;
                pend_n = 1'b0;
            end else if (xfer && legal) begin
                div_n = CFG_DIV;
            end
        end else begin
            if (wrap && pend_q) begin
                div_n  = pdiv_q;
                pend_n = 1'b0;
            end
            if (xfer && legal) begin
                pdiv_n = CFG_DIV;
                pend_n = 1'b1;
            end
        end

        tick_n = (state_n != STOP) && (cnt_n == '0);
        busy_n = (state_n != STOP);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= STOP;
            cnt_q      <= '0;
            ACTIVE_DIV <= DIV_W'(DEF_DIV);
            pdiv_q     <= '0;
            pend_q     <= 1'b0;
            clk_a_q    <= 1'b0;
            odd_q      <= 1'b0;
            TICK       <= 1'b0;
            BUSY       <= 1'b0;
            CFG_READY  <= 1'b1;
            CFG_ERR    <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            ACTIVE_DIV <= div_n;
            pdiv_q     <= pdiv_n;
            pend_q     <= pend_n;
            clk_a_q    <= clk_a_n;
            odd_q      <= ACTIVE_DIV[0];
            TICK       <= tick_n;
            BUSY       <= busy_n;
            CFG_READY  <= !pend_n;
            CFG_ERR    <= err_n;
        end
    end

    // Half-cycle delayed copy trims the high phase by half a CLK for odd ratios.
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) clk_b_q <= 1'b0;
        else     clk_b_q <= clk_a_q;
    end

    assign CLK_OUT = clk_a_q & (clk_b_q | ~odd_q);

`ifdef CLK_DIV_SCHED_STAT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)       PERIOD_CNT <= '0;
        else if (wrap) PERIOD_CNT <= PERIOD_CNT + 32'd1;
    end
`endif

endmodule

// File: tb/tb_clk_div_sched.sv
// Testbench for clk_div_sched: fixed vectors, directed corner sequences and random stimulus
// checked against a half-cycle waveform model of the divider.
module tb_clk_div_sched;
    localparam int unsigned W = 4;

    logic         CLK, RST, EN, CFG_VALID;
    logic [W-1:0] CFG_DIV;
    logic         CFG_READY, CFG_ERR, CLK_OUT, TICK, BUSY;
    logic [W-1:0] ACTIVE_DIV;
`ifdef CLK_DIV_SCHED_STAT_EN
    logic [31:0]  PERIOD_CNT;
`endif

    clk_div_sched #(.DIV_W(W), .DEF_DIV(3)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .CFG_VALID(CFG_VALID), .CFG_DIV(CFG_DIV),
        .CFG_READY(CFG_READY), .CFG_ERR(CFG_ERR), .CLK_OUT(CLK_OUT), .TICK(TICK),
        .BUSY(BUSY), .ACTIVE_DIV(ACTIVE_DIV)
`ifdef CLK_DIV_SCHED_STAT_EN
        , .PERIOD_CNT(PERIOD_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: periods as whole units, CLK_OUT as a schedule of half-cycle samples.
    bit m_run, m_pend, m_prev_en;
    int m_div, m_pdiv, m_left;
    bit wave [64];
    int hidx;
    bit e_tick, e_err, exp_pos, exp_neg;

    bit s_pos, s_neg, s_tick, s_busy, s_rdy, s_err;
    int s_act;
    int hi_cnt, run_cur, run_max;

    typedef struct {
        logic         en;
        logic         vld;
        logic [W-1:0] div;
        logic         busy;
        logic         rdy;
        logic         err;
        logic [W-1:0] act;
        logic         tick;
        logic         clk;
    } vec_t;
    vec_t vec [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pend = 0; m_prev_en = 0;
        m_div = 3; m_pdiv = 0; m_left = 0;
        for (int k = 0; k < 64; k++) wave[k] = 0;
    endtask

    task automatic track(input bit v);
        if (v) begin
            hi_cnt++;
            run_cur++;
            if (run_cur > run_max) run_max = run_cur;
        end else begin
            run_cur = 0;
        end
    endtask

    task automatic clr_track();
        hi_cnt = 0; run_cur = 0; run_max = 0;
    endtask

    task automatic model_edge();
        bit xfer, legal, start, pend_old;
        pend_old = m_pend;
        xfer     = CFG_VALID && !m_pend;
        legal    = (CFG_DIV >= 2);
        e_err    = xfer && !legal;
        start    = 0;
        if (!m_run) begin
            if (m_pend) begin m_div = m_pdiv; m_pend = 0; end
            else if (xfer && legal) m_div = int'(CFG_DIV);
            if (EN) begin m_run = 1; start = 1; end
        end else begin
            if (m_left == 1) begin
                if (pend_old) begin m_div = m_pdiv; m_pend = 0; end
                if (!EN && !m_prev_en) m_run = 0;
                else start = 1;
            end else begin
                m_left--;
            end
            if (xfer && legal) begin m_pdiv = int'(CFG_DIV); m_pend = 1; end
        end
        m_prev_en = EN;
        exp_pos = wave[hidx % 64];
        wave[hidx % 64] = 0;
        // A period of D cycles is D high half-cycles then D low, starting 1 CLK (even) or 1.5 CLK (odd) later.
        if (start) begin
            m_left = m_div;
            for (int k = 0; k < 2 * m_div; k++)
                wave[(hidx + ((m_div % 2 == 1) ? 3 : 2) + k) % 64] = (k < m_div);
        end
        e_tick = start;
        hidx++;
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        chk("clk_out_pos", CLK_OUT, exp_pos);
        chk("tick", TICK, e_tick);
        chk("busy", BUSY, m_run);
        chk("cfg_ready", CFG_READY, !m_pend);
        chk("cfg_err", CFG_ERR, e_err);
        chk("active_div", ACTIVE_DIV, m_div);
        s_pos = CLK_OUT; s_tick = TICK; s_busy = BUSY; s_rdy = CFG_READY; s_err = CFG_ERR;
        s_act = int'(ACTIVE_DIV);
        track(CLK_OUT);
        @(negedge CLK);
        exp_neg = wave[hidx % 64];
        wave[hidx % 64] = 0;
        hidx++;
        #1;
        chk("clk_out_neg", CLK_OUT, exp_neg);
        s_neg = CLK_OUT;
        track(CLK_OUT);
    endtask

    initial begin
        int n;
        bit found, busy_ok;

        //            en    vld   div    busy  rdy   err   act    tick  clk
        vec[0]  = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd3,  1'b0, 1'b0};
        vec[1]  = '{1'b0, 1'b1, 4'd0,  1'b0, 1'b1, 1'b1, 4'd3,  1'b0, 1'b0};
        vec[2]  = '{1'b0, 1'b1, 4'd1,  1'b0, 1'b1, 1'b1, 4'd3,  1'b0, 1'b0};
        vec[3]  = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd3,  1'b0, 1'b0};
        vec[4]  = '{1'b0, 1'b1, 4'd4,  1'b0, 1'b1, 1'b0, 4'd4,  1'b0, 1'b0};
        vec[5]  = '{1'b0, 1'b1, 4'd15, 1'b0, 1'b1, 1'b0, 4'd15, 1'b0, 1'b0};
        vec[6]  = '{1'b0, 1'b1, 4'd2,  1'b0, 1'b1, 1'b0, 4'd2,  1'b0, 1'b0};
        vec[7]  = '{1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd2,  1'b1, 1'b0};
        vec[8]  = '{1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd2,  1'b0, 1'b1};
        vec[9]  = '{1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd2,  1'b1, 1'b0};
        vec[10] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd2,  1'b0, 1'b1};
        vec[11] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd2,  1'b0, 1'b0};

        CLK = 0; RST = 0; EN = 0; CFG_VALID = 0; CFG_DIV = '0;
        hidx = 0;
        model_reset();
        clr_track();
        #1 RST = 1;
        #1;
        chk("rst_clk_out", CLK_OUT, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_ready", CFG_READY, 1'b1);
        chk("rst_active_div", ACTIVE_DIV, 4'd3);
        chk("rst_tick", TICK, 1'b0);
        chk("rst_err", CFG_ERR, 1'b0);
        repeat (2) @(negedge CLK);
        #1 RST = 0;

        // Idle after reset with EN low.
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_clk", s_pos | s_neg, 1'b0);
            chk("idle_active_div", s_act, 3);
        end

        for (int i = 0; i < 12; i++) begin
            EN = vec[i].en; CFG_VALID = vec[i].vld; CFG_DIV = vec[i].div;
            step();
            chk($sformatf("vec%0d_busy", i), s_busy, vec[i].busy);
            chk($sformatf("vec%0d_ready", i), s_rdy, vec[i].rdy);
            chk($sformatf("vec%0d_err", i), s_err, vec[i].err);
            chk($sformatf("vec%0d_active", i), s_act, vec[i].act);
            chk($sformatf("vec%0d_tick", i), s_tick, vec[i].tick);
            chk($sformatf("vec%0d_clk", i), s_pos, vec[i].clk);
        end
        EN = 0; CFG_VALID = 0;

        // D=4 from idle: first rise one CLK after EN is sampled, TICK every 4.
        CFG_VALID = 1; CFG_DIV = 4'd4; step(); CFG_VALID = 0;
        EN = 1; step();
        chk("d4_start_pos", s_pos, 1'b0);
        chk("d4_start_neg", s_neg, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 1) chk("d4_first_rise", s_pos, 1'b1);
            chk($sformatf("d4_tick%0d", i), s_tick, (i % 4) == 0);
        end

        // Retune 4 -> 5 mid-period.
        step();
        CFG_VALID = 1; CFG_DIV = 4'd5; step(); CFG_VALID = 0;
        chk("rt_ready_low", s_rdy, 1'b0);
        chk("rt_div_kept", s_act, 4);
        step();
        chk("rt_ready_low2", s_rdy, 1'b0);
        step();
        chk("rt_wrap_tick", s_tick, 1'b1);
        chk("rt_div_new", s_act, 5);
        chk("rt_ready_back", s_rdy, 1'b1);
        repeat (5) step();
        chk("rt_tick_p5", s_tick, 1'b1);
        clr_track();
        repeat (10) step();
        chk("d5_high_halves", hi_cnt, 10);
        chk("d5_high_run", run_max, 5);

        // D=6, drop EN at cnt=1, drain to STOP.
        CFG_VALID = 1; CFG_DIV = 4'd6; step(); CFG_VALID = 0;
        for (int i = 0; i < 12 && ACTIVE_DIV != 4'd6; i++) step();
        chk("d6_loaded", s_act, 6);
        chk("d6_tick", s_tick, 1'b1);
        step();
        EN = 0; step();
        n = 0;
        do begin step(); n++; end while (s_busy && n < 20);
        chk("drain_cycles", n, 4);
        chk("drain_low", s_pos | s_neg, 1'b0);

        // Reassert EN at cnt=3 of the draining period: no gap.
        EN = 1; step(); step();
        EN = 0; step(); step();
        EN = 1; step();
        clr_track();
        busy_ok = 1;
        repeat (12) begin step(); busy_ok &= s_busy; end
        chk("reassert_busy", busy_ok, 1'b1);
        chk("reassert_high_halves", hi_cnt, 12);

        // Illegal ratios while running.
        CFG_VALID = 1; CFG_DIV = 4'd0; step(); CFG_VALID = 0;
        chk("err0_pulse", s_err, 1'b1);
        chk("err0_div", s_act, 6);
        chk("err0_ready", s_rdy, 1'b1);
        step();
        chk("err0_clear", s_err, 1'b0);
        CFG_VALID = 1; CFG_DIV = 4'd1; step(); CFG_VALID = 0;
        chk("err1_pulse", s_err, 1'b1);
        chk("err1_div", s_act, 6);
        step();
        chk("err1_clear", s_err, 1'b0);

        // D=7: 3.5 CLK high, then asynchronous reset while CLK_OUT is high.
        CFG_VALID = 1; CFG_DIV = 4'd7; step(); CFG_VALID = 0;
        for (int i = 0; i < 12 && ACTIVE_DIV != 4'd7; i++) step();
        chk("d7_loaded", s_act, 7);
        clr_track();
        repeat (7) step();
        chk("d7_high_run", run_max, 7);
        chk("d7_high_halves", hi_cnt, 7);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin step(); found = s_pos && s_neg; end
        chk("d7_high_found", found, 1'b1);
        #2;
        chk("pre_rst_high", CLK_OUT, 1'b1);
        RST = 1; EN = 0;
        #1;
        chk("arst_clk_out", CLK_OUT, 1'b0);
        chk("arst_busy", BUSY, 1'b0);
        chk("arst_ready", CFG_READY, 1'b1);
        chk("arst_active_div", ACTIVE_DIV, 4'd3);
        chk("arst_tick", TICK, 1'b0);
        chk("arst_err", CFG_ERR, 1'b0);
        model_reset();
        @(negedge CLK);
        #1 RST = 0;

        // Default D=3: first rise 1.5 CLK after EN is sampled.
        EN = 1; step();
        step();
        chk("d3_rise_pos", s_pos, 1'b0);
        chk("d3_rise_neg", s_neg, 1'b1);
        EN = 0;
        for (int i = 0; i < 10 && BUSY; i++) step();
        chk("d3_stopped", s_busy, 1'b0);

        // Largest ratio 2^W-1.
        CFG_VALID = 1; CFG_DIV = 4'd15; step(); CFG_VALID = 0;
        EN = 1; step();
        chk("d15_start_tick", s_tick, 1'b1);
        clr_track();
        n = 0;
        do begin step(); n++; end while (!s_tick && n < 40);
        chk("d15_period", n, 15);
        chk("d15_high_run", run_max, 15);

        // Random traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(7) == 0) EN = ~EN;
            CFG_VALID = ($urandom_range(5) == 0);
            CFG_DIV   = W'($urandom_range(15));
            step();
        end
        CFG_VALID = 0; EN = 0;
        repeat (40) step();
        chk("final_stopped", s_busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
